data_mem_responder: RTL and testbench

Memory-side responder for the pipeline's M-stage load/store port: accepts one word request at a time from the processor's data-memory initiator, services it after a programmable number of wait states, and returns read data with a one-cycle ready pulse. While a request is outstanding it drives a stall request that the hazard logic uses to freeze F/D/E/M. It sits between the datapath's M stage and the data RAM, replacing a zero-latency combinational memory.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/mem_ram_1rw.sv | 27 ++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the M-stage data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_W   = 32;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    // True when a byte address falls inside a RAM of 'depth' 32-bit words.
    function automatic logic addr_in_range(input logic [63:0] addr, input int depth);
        return addr < (64'(depth) << 2);
    endfunction

endpackage

// File: rtl/mem_ram_1rw.sv
// Single-port word RAM: synchronous write, asynchronous read. Contents are
// deliberately not reset so data survives a pipeline reset.
module mem_ram_1rw
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Write port: one word per clock when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the M-stage load/store port. Accepts one request
// at a time, waits WAIT cycles, then answers with a one-cycle ready pulse.
// Dropping req before the response aborts the access (pipeline flush).
//
// Handshake: the initiator raises req with we/addr/wdata and holds req until
// it sees ready; fields are captured only in the accepting IDLE cycle. ready
// is high for exactly the RESP cycle and only while req is still high.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              stall_m,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);

    if (WAIT < 0 || WAIT > MAX_WAIT) begin : g_bad_wait
        $error("data_mem_responder: WAIT must be in 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_mem_responder: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
        $error("data_mem_responder: ADDR_W too narrow for DEPTH");
    end

    dmem_state_t       r_state;
    dmem_state_t       w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_ready;
    logic              w_err_cond;
    logic              w_ram_we;
    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_accept   = (r_state == IDLE) && req;
    assign w_ready    = (r_state == RESP) && req;
    // Error is judged on the captured address, never on the live bus.
    assign w_err_cond = (r_addr[1:0] != 2'b00) || !addr_in_range(64'(r_addr), DEPTH);
    assign w_ram_we   = w_ready && r_we && !w_err_cond;
    assign w_idx      = r_addr[IDX_W+1:2];

    mem_ram_1rw #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(WAIT);
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end else if (r_state == BUSY) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    // Next-state logic; a dropped req in BUSY or RESP is a flush.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next_state = (WAIT == 0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    w_next_state = IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs: data and err are only meaningful in the ready cycle.
    always_comb begin
        ready   = w_ready;
        err     = w_ready && w_err_cond;
        rdata   = (w_ready && !w_err_cond && !r_we) ? w_ram_rdata : '0;
        busy    = (r_state == BUSY) || (r_state == RESP);
        stall_m = req && !w_ready;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with WAIT = 0, 2 and 3.
module tb_data_mem_responder;

    localparam int N = 3;

    logic        clk;
    logic        reset;
    logic        req_v   [N];
    logic        we_v    [N];
    logic [31:0] addr_v  [N];
    logic [31:0] wdata_v [N];
    logic [31:0] rdata_v [N];
    logic        ready_v [N];
    logic        err_v   [N];
    logic        stall_v [N];
    logic        busy_v  [N];

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q0[$];
    logic [32:0] exp_q1[$];
    logic [32:0] exp_q2[$];
    logic        prev_ready [N];

    data_mem_responder #(.ADDR_W(32), .DEPTH(64), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]),
        .stall_m(stall_v[0]), .busy(busy_v[0])
    );
    data_mem_responder #(.ADDR_W(32), .DEPTH(64), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]),
        .stall_m(stall_v[1]), .busy(busy_v[1])
    );
    data_mem_responder #(.ADDR_W(32), .DEPTH(64), .WAIT(3)) u_w3 (
        .clk(clk), .reset(reset), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]),
        .stall_m(stall_v[2]), .busy(busy_v[2])
    );

    // Clock / watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void push_exp(input int d, input logic [32:0] v);
        case (d)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic int q_size(input int d);
        case (d)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [32:0] pop_exp(input int d);
        case (d)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ready pulse consumes one expected {err, rdata}.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < N; d++) begin
                check("stall_m", stall_v[d], req_v[d] & ~ready_v[d]);
                if (ready_v[d]) begin
                    check("back_to_back_ready", prev_ready[d], 1'b0);
                    if (q_size(d) == 0) begin
                        check("unexpected_ready", ready_v[d], 1'b0);
                    end else begin
                        check("response", {err_v[d], rdata_v[d]}, pop_exp(d));
                    end
                end else begin
                    check("quiet_outputs", {err_v[d], rdata_v[d]}, 33'h0);
                end
                prev_ready[d] = ready_v[d];
            end
        end else begin
            for (int d = 0; d < N; d++) prev_ready[d] = 1'b0;
        end
    end

    // Driver: one full transaction; entered and left just after a rising edge.
    task automatic xact(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_e,
                        input logic [31:0] exp_rd, input bit toggle);
        int cyc;
        bit got;
        we_v[d]    = w;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        req_v[d]   = 1'b1;
        push_exp(d, {exp_e, exp_rd});
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (ready_v[d]) begin
                got = 1;
            end else begin
                check("stall_while_waiting", stall_v[d], 1'b1);
                cyc++;
                @(posedge clk);
                #1;
                if (toggle && cyc == 1) begin
                    addr_v[d]  = addr_v[d] ^ 32'h4;
                    wdata_v[d] = ~wdata_v[d];
                end
            end
        end
        if (got) check("latency", 64'(cyc), 64'(wait_of(d) + 1));
        else     check("ready_timeout", got, 1'b1);
        @(posedge clk);
        #1;
        req_v[d] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rnd_data;
        int          rnd_idx;

        reset = 1'b0;
        for (int d = 0; d < N; d++) begin
            req_v[d] = 0; we_v[d] = 0; addr_v[d] = 0; wdata_v[d] = 0; prev_ready[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check("reset_ready", ready_v[d], 1'b0);
            check("reset_err",   err_v[d],   1'b0);
            check("reset_rdata", rdata_v[d], 32'h0);
            check("reset_busy",  busy_v[d],  1'b0);
            check("reset_stall", stall_v[d], 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table of {instance, we, addr, wdata, err, rdata}.
        vecs.push_back('{1, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{0, 1'b1, 32'h0,   32'h11,       1'b0, 32'h0});
        vecs.push_back('{0, 1'b1, 32'h4,   32'h22,       1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h11});
        vecs.push_back('{0, 1'b0, 32'h4,   32'h0,        1'b0, 32'h22});
        vecs.push_back('{0, 1'b1, 32'h6,   32'h99,       1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h2,   32'h0,        1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 32'h4,   32'h0,        1'b0, 32'h22});
        vecs.push_back('{0, 1'b1, 32'hFC,  32'hCAFEF00D, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'hCAFEF00D});
        vecs.push_back('{2, 1'b1, 32'h8,   32'h1111,     1'b0, 32'h0});
        vecs.push_back('{2, 1'b1, 32'hC,   32'h2222,     1'b0, 32'h0});
        vecs.push_back('{1, 1'b1, 32'h24,  32'h7777,     1'b0, 32'h0});
        vecs.push_back('{1, 1'b1, 32'h28,  32'h3333,     1'b0, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            xact(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].e, vecs[i].rd, 1'b0);
        end
        idle_cycles(2);

        // Abort in the second BUSY cycle: no ready, no write.
        we_v[2] = 1'b1; addr_v[2] = 32'h8; wdata_v[2] = 32'h55; req_v[2] = 1'b1;
        @(posedge clk); #1;
        check("abort_busy_entered", busy_v[2], 1'b1);
        @(posedge clk); #1;
        req_v[2] = 1'b0;
        @(posedge clk); #1;
        check("abort_back_to_idle", busy_v[2], 1'b0);
        idle_cycles(5);
        xact(2, 1'b0, 32'h8, 32'h0, 1'b0, 32'h1111, 1'b0);

        // Abort in the RESP cycle itself: ready suppressed, no write.
        we_v[1] = 1'b1; addr_v[1] = 32'h28; wdata_v[1] = 32'hBAD; req_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        #1;
        check("resp_abort_ready", ready_v[1], 1'b0);
        check("resp_abort_busy",  busy_v[1],  1'b1);
        @(posedge clk); #1;
        check("resp_abort_idle", busy_v[1], 1'b0);
        idle_cycles(2);
        xact(1, 1'b0, 32'h28, 32'h0, 1'b0, 32'h3333, 1'b0);

        // Reset mid-BUSY: pending store dropped, outputs clear immediately.
        we_v[2] = 1'b1; addr_v[2] = 32'hC; wdata_v[2] = 32'hAA; req_v[2] = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_busy", busy_v[2], 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_busy",  busy_v[2],  1'b0);
        check("async_reset_ready", ready_v[2], 1'b0);
        req_v[2] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(1);
        xact(2, 1'b0, 32'hC, 32'h0, 1'b0, 32'h2222, 1'b0);

        // Request fields changed after acceptance must be ignored.
        xact(1, 1'b1, 32'h20, 32'h1234, 1'b0, 32'h0, 1'b1);
        xact(1, 1'b0, 32'h20, 32'h0,    1'b0, 32'h1234, 1'b0);
        xact(1, 1'b0, 32'h24, 32'h0,    1'b0, 32'h7777, 1'b0);
        xact(1, 1'b0, 32'h20, 32'h0,    1'b0, 32'h1234, 1'b1);

        // Random aligned store/load pairs on the zero-wait instance.
        for (int i = 0; i < 8; i++) begin
            rnd_idx  = $urandom_range(16, 31);
            rnd_data = $urandom;
            xact(0, 1'b1, 32'(rnd_idx * 4), rnd_data, 1'b0, 32'h0, 1'b0);
            xact(0, 1'b0, 32'(rnd_idx * 4), 32'h0,    1'b0, rnd_data, 1'b0);
        end

        idle_cycles(4);
        for (int d = 0; d < N; d++) begin
            check("queue_drained", 64'(q_size(d)), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
